// File: rtl/tt_cpu_loader_bridge.sv
// rtl/tt_cpu_loader_bridge.sv - byte-serial program loader, LOAD/RUN/IDLE sequencer and result-lane bridge.
// Optional running XOR checksum of loaded bytes is enabled by defining LOADER_CHECKSUM_EN.
module tt_cpu_loader_bridge #(
  parameter int DATAWIDTH = 32,
  parameter int ADDWIDTH  = 7,
  parameter int PM_DEPTH  = 128,
  parameter int LANE_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  input  logic                 load_mode,
  input  logic [DATAWIDTH-1:0] result_in,
  input  logic [LANE_W-1:0]    lane_sel,
  output logic                 pm_wr_en,
  output logic [ADDWIDTH-1:0]  pm_addr,
  output logic [DATAWIDTH-1:0] pm_wr_data,
  output logic                 cpu_run,
  output logic [7:0]           byte_out,
  output logic                 overflow,
  output logic                 partial_err,
  output logic [7:0]           checksum
);

  localparam int BPW   = DATAWIDTH / 8;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int WC_W  = ADDWIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10
  } state_e;

  state_e               state_q, state_d;
  logic                 loaded_q, loaded_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATAWIDTH-1:0] word_q, word_d;
  logic [WC_W-1:0]      wcnt_q, wcnt_d;
  logic                 pm_wr_en_q, pm_wr_en_d;
  logic [DATAWIDTH-1:0] pm_wr_data_q, pm_wr_data_d;
  logic                 overflow_q, overflow_d;
  logic                 partial_err_q, partial_err_d;
  logic [7:0]           byte_out_q, byte_out_d;

  logic                 accept;
  logic                 load_entry;
  logic                 load_exit;
  logic [DATAWIDTH-1:0] word_shift;
  logic [WC_W-1:0]      wcnt_eff;
  logic [7:0]           lane_byte;
  logic [3:0]           addr_nib;

  // Little-endian assembly: each new byte enters at the top, so the first byte ends in [7:0].
  if (BPW > 1) begin : g_shift
    assign word_shift = {byte_in, word_q[DATAWIDTH-1:8]};
  end else begin : g_single
    assign word_shift = byte_in;
  end

  always_comb begin
    state_d  = state_q;
    loaded_d = loaded_q;
    case (state_q)
      ST_IDLE: begin
        if (load_mode) begin
          state_d = ST_LOAD;
        end else if (loaded_q) begin
          state_d = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (!load_mode) begin
          state_d  = ST_RUN;
          loaded_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (load_mode) begin
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bytes arriving in the exit cycle are not taken, so a completed word can never write while running.
  assign load_entry = (state_q != ST_LOAD) && (state_d == ST_LOAD);
  assign load_exit  = (state_q == ST_LOAD) && !load_mode;
  assign accept     = (state_q == ST_LOAD) && load_mode && byte_valid;
  // A write still on the bus has not bumped the address yet; count it when judging fullness.
  assign wcnt_eff   = wcnt_q + WC_W'(pm_wr_en_q);

  always_comb begin
    cnt_d         = cnt_q;
    word_d        = word_q;
    wcnt_d        = pm_wr_en_q ? (wcnt_q + 1'b1) : wcnt_q;
    pm_wr_en_d    = 1'b0;
    pm_wr_data_d  = pm_wr_data_q;
    overflow_d    = overflow_q;
    partial_err_d = partial_err_q;
    if (load_entry) begin
      cnt_d         = '0;
      wcnt_d        = '0;
      overflow_d    = 1'b0;
      partial_err_d = 1'b0;
    end else if (accept) begin
      word_d = word_shift;
      if (cnt_q == CNT_W'(BPW - 1)) begin
        cnt_d = '0;
        if (wcnt_eff < WC_W'(PM_DEPTH)) begin
          pm_wr_en_d   = 1'b1;
          pm_wr_data_d = word_shift;
        end else begin
          overflow_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (load_exit && (cnt_q != '0)) begin
      cnt_d         = '0;
      partial_err_d = 1'b1;
    end
  end

  assign addr_nib = 4'(wcnt_q[ADDWIDTH-1:0]);

  always_comb begin
    lane_byte = 8'h00;
    for (int i = 0; i < BPW; i++) begin
      if (lane_sel == LANE_W'(i)) begin
        lane_byte = result_in[8*i +: 8];
      end
    end
    if (state_q == ST_RUN) begin
      byte_out_d = lane_byte;
    end else begin
      byte_out_d = {state_q, overflow_q, partial_err_q, addr_nib};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      loaded_q      <= 1'b0;
      cnt_q         <= '0;
      word_q        <= '0;
      wcnt_q        <= '0;
      pm_wr_en_q    <= 1'b0;
      pm_wr_data_q  <= '0;
      overflow_q    <= 1'b0;
      partial_err_q <= 1'b0;
      byte_out_q    <= 8'h00;
    end else begin
      state_q       <= state_d;
      loaded_q      <= loaded_d;
      cnt_q         <= cnt_d;
      word_q        <= word_d;
      wcnt_q        <= wcnt_d;
      pm_wr_en_q    <= pm_wr_en_d;
      pm_wr_data_q  <= pm_wr_data_d;
      overflow_q    <= overflow_d;
      partial_err_q <= partial_err_d;
      byte_out_q    <= byte_out_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (load_entry) begin
      checksum_d = 8'h00;
    end else if (accept) begin
      checksum_d = checksum_q ^ byte_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= 8'h00;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 8'h00;
`endif

  assign pm_wr_en    = pm_wr_en_q;
  assign pm_addr     = wcnt_q[ADDWIDTH-1:0];
  assign pm_wr_data  = pm_wr_data_q;
  assign cpu_run     = (state_q == ST_RUN);
  assign byte_out    = byte_out_q;
  assign overflow    = overflow_q;
  assign partial_err = partial_err_q;

endmodule
